// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------+
// | alu_pkg -- opcodes, flag indices and widths for the ALU     |
// | Rev 1.0                                                     |
// +------------------------------------------------------------+
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int FLAGW = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;

  // Shifter modes match the low two opcode bits of the shift group.
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam int F_Z = 2;
  localparam int F_V = 1;
  localparam int F_N = 0;

endpackage
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// +------------------------------------------------------------+
// | alu_shifter -- 16-bit log barrel shifter (SLL/SRL/SRA/ROR)  |
// | Rev 1.0                                                     |
// +------------------------------------------------------------+
module alu_shifter
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stg [0:4];

  assign stg[0] = din;

  // Stage k moves the data by 2**k; right shifts take their fill from the
  // wrapped low bits (ROR) or the sign bit, which earlier stages preserve (SRA).
  for (genvar k = 0; k < 4; k++) begin : g_stage
    localparam int N = 1 << k;
    logic [N-1:0]     fill;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    assign fill = (mode == SH_ROR) ? stg[k][N-1:0]
                                   : {N{(mode == SH_SRA) & stg[k][WIDTH-1]}};
    assign shl  = {stg[k][WIDTH-1-N:0], {N{1'b0}}};
    assign shr  = {fill, stg[k][WIDTH-1:N]};
    assign stg[k+1] = !amt[k]          ? stg[k] :
                      (mode == SH_SLL) ? shl    : shr;
  end

  assign dout = stg[4];

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +------------------------------------------------------------+
// | alu -- 16-bit ALU, one-cycle registered result and Z/V/N    |
// | Rev 1.0                                                     |
// +------------------------------------------------------------+
module alu #(
  parameter int WIDTH = 16,
  parameter int FLAGW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic [FLAGW-1:0] lastFlag,
  input  logic [3:0]       imm,
  output logic [WIDTH-1:0] out,
  output logic [FLAGW-1:0] flag
);
  import alu_pkg::*;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] res;
  logic [FLAGW-1:0] flag_d;
  logic             arith;
  logic             ovf;

  assign sum  = A + B;
  assign diff = A - B;

  alu_shifter u_shifter (
    .din  (A),
    .amt  (imm),
    .mode (op[1:0]),
    .dout (shifted)
  );

  always_comb begin
    res   = shifted;
    arith = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum;
        arith = 1'b1;
        ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff;
        arith = 1'b1;
        ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      default: res = shifted;
    endcase
  end

  // V and N carry over from the caller's flags unless the op is arithmetic.
  always_comb begin
    flag_d      = lastFlag;
    flag_d[F_Z] = (res == '0);
    if (arith) begin
      flag_d[F_V] = ovf;
      flag_d[F_N] = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      flag <= '0;
    end else begin
      out  <= res;
      flag <= flag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// +------------------------------------------------------------+
// | tb_alu -- directed and random checks of alu vs. a model     |
// | Rev 1.0                                                     |
// +------------------------------------------------------------+
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  op;
  logic [2:0]  lastFlag;
  logic [3:0]  imm;
  logic [15:0] out;
  logic [2:0]  flag;

  int vectors;
  int miscompares;

  alu #(.WIDTH(16), .FLAGW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .op       (op),
    .lastFlag (lastFlag),
    .imm      (imm),
    .out      (out),
    .flag     (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic on the opcode table, returns {flag, out}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] o, input logic [3:0] sh,
                                        input logic [2:0] lf);
    int          sa;
    int          sb;
    int          t;
    int          s;
    logic [15:0] r;
    logic        z;
    logic        v;
    logic        n;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = lf[1];
    n  = lf[0];
    case (o)
      3'd0: begin s = sa + sb; t = s; v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; t = s; v = (s > 32767) || (s < -32768); end
      3'd2: t = int'(a & b);
      3'd3: t = int'(a | b);
      3'd4: t = int'(a) << sh;
      3'd5: t = int'(a) >> sh;
      3'd6: t = sa >>> sh;
      default: t = (int'(a) >> sh) | (int'(a) << (16 - int'(sh)));
    endcase
    r = t[15:0];
    z = (r == 16'h0000);
    if (o == 3'd0 || o == 3'd1) n = r[15];
    return {z, v, n, r};
  endfunction

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                     input logic [3:0] sh, input logic [2:0] lf,
                     input logic [15:0] exp_out, input logic [2:0] exp_flag,
                     input string tag);
    A = a; B = b; op = o; imm = sh; lastFlag = lf;
    @(posedge clk);
    #1;
    vectors++;
    assert (out === exp_out) else begin
      miscompares++;
      $error("FAIL %s out: observed %h expected %h", tag, out, exp_out);
    end
    vectors++;
    assert (flag === exp_flag) else begin
      miscompares++;
      $error("FAIL %s flag: observed %b expected %b", tag, flag, exp_flag);
    end
  endtask

  initial begin
    logic [18:0] m;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  ro;
    logic [3:0]  ri;
    logic [2:0]  rl;
    vectors     = 0;
    miscompares = 0;

    rst_n = 1'b0;
    A = 16'hFFFF; B = 16'hFFFF; op = 3'd0; imm = 4'd0; lastFlag = 3'b000;
    #1;
    vectors++;
    assert (out === 16'h0000 && flag === 3'b000) else begin
      miscompares++;
      $error("FAIL reset_async: observed %h/%b expected 0000/000", out, flag);
    end
    @(posedge clk);
    #1;
    vectors++;
    assert (out === 16'h0000 && flag === 3'b000) else begin
      miscompares++;
      $error("FAIL reset_hold: observed %h/%b expected 0000/000", out, flag);
    end
    rst_n = 1'b1;
    run(16'hFFFF, 16'hFFFF, 3'd0, 4'd0, 3'b000, 16'hFFFE, 3'b001, "reset_release");

    run(16'h7FFF, 16'h0001, 3'd0, 4'd0, 3'b000, 16'h8000, 3'b011, "add_ovf");
    run(16'h8000, 16'h0001, 3'd1, 4'd0, 3'b000, 16'h7FFF, 3'b010, "sub_ovf");
    run(16'h1234, 16'h1234, 3'd1, 4'd0, 3'b011, 16'h0000, 3'b100, "sub_zero");
    run(16'hF0F0, 16'h0F0F, 3'd2, 4'd0, 3'b011, 16'h0000, 3'b111, "and_pass");
    run(16'hF0F0, 16'h0F0F, 3'd3, 4'd0, 3'b011, 16'hFFFF, 3'b011, "or_pass");
    run(16'h8001, 16'hABCD, 3'd4, 4'd4, 3'b000, 16'h0010, 3'b000, "sll4");
    run(16'h8001, 16'hABCD, 3'd5, 4'd4, 3'b000, 16'h0800, 3'b000, "srl4");
    run(16'h8001, 16'hABCD, 3'd6, 4'd4, 3'b000, 16'hF800, 3'b000, "sra4");
    run(16'h8001, 16'hABCD, 3'd7, 4'd4, 3'b000, 16'h1800, 3'b000, "ror4");
    run(16'h8001, 16'h0000, 3'd4, 4'd0, 3'b000, 16'h8001, 3'b000, "sll0");
    run(16'h8001, 16'h0000, 3'd5, 4'd0, 3'b000, 16'h8001, 3'b000, "srl0");
    run(16'h8001, 16'h0000, 3'd6, 4'd0, 3'b000, 16'h8001, 3'b000, "sra0");
    run(16'h8001, 16'h0000, 3'd7, 4'd0, 3'b000, 16'h8001, 3'b000, "ror0");
    run(16'h8000, 16'h0000, 3'd6, 4'd15, 3'b101, 16'hFFFF, 3'b001, "sra15");
    run(16'h0001, 16'h0000, 3'd7, 4'd15, 3'b010, 16'h0002, 3'b010, "ror15");

    // Mid-stream reset between edges, then recovery on the current inputs.
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    assert (out === 16'h0000 && flag === 3'b000) else begin
      miscompares++;
      $error("FAIL reset_mid: observed %h/%b expected 0000/000", out, flag);
    end
    A = 16'h0003; B = 16'h0004; op = 3'd0; imm = 4'd0; lastFlag = 3'b110;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(16'h0003, 16'h0004, 3'd0, 4'd0, 3'b110, 16'h0007, 3'b000, "post_reset");

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 0) rb = ra;
      ro = 3'($urandom);
      ri = 4'($urandom);
      rl = 3'($urandom);
      m  = model(ra, rb, ro, ri, rl);
      run(ra, rb, ro, ri, rl, m[15:0], m[18:16], "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
